// File: rtl/button_pkg.sv
`default_nettype none
// ============================================================================
// Module      : button_pkg
// Description : Shared state encoding and counter-width helper for the
//               push-button conditioning array.
// Revision    : 1.0 - initial release
// ============================================================================
package button_pkg;

    typedef enum logic [1:0] {
        BTN_IDLE      = 2'd0,
        BTN_PRESSED   = 2'd1,
        BTN_REPEATING = 2'd2
    } btn_state_t;

    // Bits needed to hold values 0..max_val; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/button_channel.sv
`default_nettype none
// ============================================================================
// Module      : button_channel
// Description : One button: 2-flop synchroniser, counter debouncer, and
//               press/repeat/release event FSM with registered outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module button_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000,
    parameter bit REPEAT_EN       = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_button,
    output logic o_held,
    output logic o_press,
    output logic o_release
);

    localparam int DB_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = cnt_width(RPT_MAX);

    localparam logic [DB_W-1:0]  c_DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] c_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] c_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic [1:0]       r_sync;
    logic             r_level;
    logic [DB_W-1:0]  r_db_cnt;
    btn_state_t       r_state;
    logic [RPT_W-1:0] r_rpt_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync   <= 2'b00;
            r_level  <= 1'b0;
            r_db_cnt <= '0;
        end else if (i_clr) begin
            r_sync   <= 2'b00;
            r_level  <= 1'b0;
            r_db_cnt <= '0;
        end else begin
            r_sync <= {r_sync[0], i_button};
            // Any return to the accepted level restarts the stability count.
            if (r_sync[1] == r_level) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == c_DB_LAST) begin
                r_level  <= ~r_level;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end
        end
    end

    // Event FSM trails the debounced level by one edge so held/press/release
    // all come straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= BTN_IDLE;
            r_rpt_cnt <= '0;
            o_held    <= 1'b0;
            o_press   <= 1'b0;
            o_release <= 1'b0;
        end else if (i_clr) begin
            r_state   <= BTN_IDLE;
            r_rpt_cnt <= '0;
            o_held    <= 1'b0;
            o_press   <= 1'b0;
            o_release <= 1'b0;
        end else begin
            o_press   <= 1'b0;
            o_release <= 1'b0;
            case (r_state)
                BTN_IDLE: begin
                    if (r_level) begin
                        r_state   <= BTN_PRESSED;
                        r_rpt_cnt <= '0;
                        o_held    <= 1'b1;
                        o_press   <= 1'b1;
                    end
                end
                BTN_PRESSED: begin
                    if (!r_level) begin
                        r_state   <= BTN_IDLE;
                        r_rpt_cnt <= '0;
                        o_held    <= 1'b0;
                        o_release <= 1'b1;
                    end else if (REPEAT_EN) begin
                        if (r_rpt_cnt == c_DELAY_LAST) begin
                            r_state   <= BTN_REPEATING;
                            r_rpt_cnt <= '0;
                            o_press   <= 1'b1;
                        end else begin
                            r_rpt_cnt <= r_rpt_cnt + RPT_W'(1);
                        end
                    end
                end
                BTN_REPEATING: begin
                    // Release is checked first so it beats a coincident repeat.
                    if (!r_level) begin
                        r_state   <= BTN_IDLE;
                        r_rpt_cnt <= '0;
                        o_held    <= 1'b0;
                        o_release <= 1'b1;
                    end else if (r_rpt_cnt == c_PERIOD_LAST) begin
                        r_rpt_cnt <= '0;
                        o_press   <= 1'b1;
                    end else begin
                        r_rpt_cnt <= r_rpt_cnt + RPT_W'(1);
                    end
                end
                default: begin
                    r_state   <= BTN_IDLE;
                    r_rpt_cnt <= '0;
                    o_held    <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/button_event_array.sv
`default_nettype none
// ============================================================================
// Module      : button_event_array
// Description : N independent debounced push-button channels with press,
//               release, held-level and optional auto-repeat events.
// Revision    : 1.0 - initial release
// ============================================================================
module button_event_array
    import button_pkg::*;
#(
    parameter int                   N_BUTTONS       = 2,
    parameter int                   DEBOUNCE_CYCLES = 1000000,
    parameter int                   REPEAT_DELAY    = 50000000,
    parameter int                   REPEAT_PERIOD   = 10000000,
    parameter logic [N_BUTTONS-1:0] REPEAT_EN       = '0
) (
    input  logic                 clk_100,
    input  logic                 a_rst_n,
    input  logic                 s_rst,
    input  logic [N_BUTTONS-1:0] button_i,
    output logic [N_BUTTONS-1:0] held_o,
    output logic [N_BUTTONS-1:0] press_o,
    output logic [N_BUTTONS-1:0] release_o,
    output logic                 any_press_o
);

    generate
        for (genvar gi = 0; gi < N_BUTTONS; gi++) begin : g_channel
            button_channel #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .REPEAT_DELAY    (REPEAT_DELAY),
                .REPEAT_PERIOD   (REPEAT_PERIOD),
                .REPEAT_EN       (REPEAT_EN[gi])
            ) u_channel (
                .clk       (clk_100),
                .rst_n     (a_rst_n),
                .i_clr     (s_rst),
                .i_button  (button_i[gi]),
                .o_held    (held_o[gi]),
                .o_press   (press_o[gi]),
                .o_release (release_o[gi])
            );
        end
    endgenerate

    // press_o bits are flops, so this OR changes on the same edge as they do.
    assign any_press_o = |press_o;

endmodule

`default_nettype wire

// File: tb/tb_button_event_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_event_array
// Description : Directed bench with an event scoreboard for button_event_array.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_event_array;

    localparam int         N   = 2;
    localparam int         DB  = 4;
    localparam int         RD  = 10;
    localparam int         RP  = 3;
    localparam logic [1:0] REN = 2'b10;

    logic       clk_100 = 1'b0;
    logic       a_rst_n = 1'b0;
    logic       s_rst   = 1'b0;
    logic [1:0] button_i = 2'b00;
    logic [1:0] held_o;
    logic [1:0] press_o;
    logic [1:0] release_o;
    logic       any_press_o;

    button_event_array #(
        .N_BUTTONS       (N),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .REPEAT_EN       (REN)
    ) dut (
        .clk_100     (clk_100),
        .a_rst_n     (a_rst_n),
        .s_rst       (s_rst),
        .button_i    (button_i),
        .held_o      (held_o),
        .press_o     (press_o),
        .release_o   (release_o),
        .any_press_o (any_press_o)
    );

    always #5 clk_100 = ~clk_100;

    int cyc = 0;
    always @(posedge clk_100) cyc <= cyc + 1;

    typedef struct {
        int at;
        int ch;
        bit is_press;
    } ev_t;

    ev_t sb[$];
    int  n_checks = 0;
    int  n_errors = 0;
    bit  mon_en   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input int at, input int ch, input bit is_press);
        ev_t e;
        e.at = at;
        e.ch = ch;
        e.is_press = is_press;
        sb.push_back(e);
    endtask

    task automatic to_cyc(input int t);
        while (cyc < t) @(negedge clk_100);
    endtask

    // Every cycle: the press/release vectors must equal exactly the events
    // scheduled for this cycle; anything extra or missing is an error.
    always @(negedge clk_100) begin : mon
        logic [1:0] ep;
        logic [1:0] er;
        if (mon_en) begin
            ep = 2'b00;
            er = 2'b00;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].at == cyc) begin
                    if (sb[i].is_press) ep[sb[i].ch] = 1'b1;
                    else                er[sb[i].ch] = 1'b1;
                    sb.delete(i);
                end
            end
            check("press_o", 32'(press_o), 32'(ep));
            check("release_o", 32'(release_o), 32'(er));
            check("any_press_o", 32'(any_press_o), 32'(|ep));
        end
    end

    initial begin : watchdog
        #200us;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int k;
        // Reset held with both buttons asserted
        a_rst_n  = 1'b0;
        button_i = 2'b11;
        repeat (3) @(negedge clk_100);
        check("rst_held", 32'(held_o), 32'h0);
        check("rst_press", 32'(press_o), 32'h0);
        check("rst_release", 32'(release_o), 32'h0);
        check("rst_any", 32'(any_press_o), 32'h0);

        // Reset release: both accepted together 6 edges after first sample
        a_rst_n = 1'b1;
        mon_en  = 1'b1;
        k = cyc;
        push(k + 7, 0, 1'b1);
        push(k + 7, 1, 1'b1);
        to_cyc(k + 6);
        check("rst_latency_pre", 32'(held_o[0]), 32'h0);
        to_cyc(k + 7);
        check("rst_latency_held", 32'(held_o), 32'h3);
        button_i = 2'b00;
        push(k + 14, 0, 1'b0);
        push(k + 14, 1, 1'b0);
        to_cyc(k + 20);
        check("rst_released", 32'(held_o), 32'h0);

        // Bounce shorter than the debounce window: no events
        button_i[0] = 1'b1; repeat (3) @(negedge clk_100);
        button_i[0] = 1'b0; repeat (1) @(negedge clk_100);
        button_i[0] = 1'b1; repeat (3) @(negedge clk_100);
        button_i[0] = 1'b0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk_100);
            check("bounce_held", 32'(held_o[0]), 32'h0);
        end

        // Clean press then release on ch0
        k = cyc;
        button_i = 2'b01;
        push(k + 7, 0, 1'b1);
        to_cyc(k + 8);
        button_i = 2'b00;
        push(k + 15, 0, 1'b0);
        to_cyc(k + 20);

        // Auto-repeat on ch1
        k = cyc;
        button_i = 2'b10;
        push(k + 7, 1, 1'b1);
        push(k + 17, 1, 1'b1);
        push(k + 20, 1, 1'b1);
        push(k + 23, 1, 1'b1);
        push(k + 26, 1, 1'b1);
        push(k + 29, 1, 1'b1);
        push(k + 32, 1, 1'b1);
        push(k + 35, 1, 1'b1);
        to_cyc(k + 7);
        check("rpt_held_start", 32'(held_o[1]), 32'h1);
        to_cyc(k + 30);
        button_i = 2'b00;
        push(k + 37, 1, 1'b0);
        to_cyc(k + 36);
        check("rpt_held_end", 32'(held_o[1]), 32'h1);
        to_cyc(k + 40);
        check("rpt_released", 32'(held_o[1]), 32'h0);

        // Long hold on ch0 with repeat disabled
        k = cyc;
        button_i = 2'b01;
        push(k + 7, 0, 1'b1);
        for (int t = k + 7; t <= k + 36; t++) begin
            to_cyc(t);
            check("norpt_held", 32'(held_o[0]), 32'h1);
            if (t == k + 30) button_i = 2'b00;
        end
        push(k + 37, 0, 1'b0);
        to_cyc(k + 42);

        // Simultaneous press on both channels
        k = cyc;
        button_i = 2'b11;
        push(k + 7, 0, 1'b1);
        push(k + 7, 1, 1'b1);
        to_cyc(k + 6);
        button_i = 2'b00;
        push(k + 13, 0, 1'b0);
        push(k + 13, 1, 1'b0);
        to_cyc(k + 18);

        // Synchronous clear while ch1 is repeating
        k = cyc;
        button_i = 2'b10;
        push(k + 7, 1, 1'b1);
        push(k + 17, 1, 1'b1);
        to_cyc(k + 18);
        s_rst = 1'b1;
        to_cyc(k + 19);
        s_rst = 1'b0;
        check("clr_held", 32'(held_o), 32'h0);
        push(k + 26, 1, 1'b1);
        to_cyc(k + 26);
        check("clr_reaccept", 32'(held_o[1]), 32'h1);
        to_cyc(k + 28);
        button_i = 2'b00;
        push(k + 35, 1, 1'b0);
        to_cyc(k + 40);

        mon_en = 1'b0;
        check("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
